// File: rtl/vga_scanout_pkg.sv
// Shared VGA timing constants and the per-pixel control word that travels
// down the scanout delay line alongside the framebuffer read.
package vga_scanout_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Syncs are carried active-high so a cleared delay line reads as "no pulse".
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic vb;
    logic first;
  } vga_tap_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port plus video pins of the scanout block.
interface vga_scanout_if #(parameter int ADDR_W = 16);
  logic              pix_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [7:0]        ram_data;
  logic [2:0]        vga_rgb;
  logic              vga_hsync;
  logic              vga_vsync;
  logic              vblank;
  logic              frame_start;

  modport master (
    input  pix_en, ram_data,
    output ram_addr, ram_re, vga_rgb, vga_hsync, vga_vsync, vblank, frame_start
  );

  modport slave (
    output pix_en, ram_data,
    input  ram_addr, ram_re, vga_rgb, vga_hsync, vga_vsync, vblank, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Stage 0 of the scanout: raster counters and per-pixel decode.
module vga_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output vga_tap_t    s0,
  output logic [14:0] s0_addr
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt, v_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    s0.act   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    s0.vs    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    s0.vb    = (v_cnt >= V_ACT);
    s0.first = (h_cnt == '0) && (v_cnt == '0);
  end

  // 4x4 replication: one framebuffer byte per 4x4 block of screen pixels.
  assign s0_addr = {v_cnt[8:2], h_cnt[9:2]};

endmodule

// File: rtl/vga_scanout.sv
// VGA framebuffer scanout: address generation, read-latency delay line and
// registered video pins.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master bus
);

  vga_tap_t             s0;
  logic [14:0]          s0_addr;
  vga_tap_t [RD_LAT:0]  dly_pipe;
  vga_tap_t             tap;
  logic                 unused_data_hi;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .pix_en (bus.pix_en),
    .s0     (s0),
    .s0_addr(s0_addr)
  );

  // Entry 0 is written with ram_addr; the tap lines up with ram_data.
  assign tap = dly_pipe[RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ram_addr  <= '0;
      dly_pipe      <= '0;
      bus.vga_rgb   <= '0;
      bus.vga_hsync <= 1'b1;
      bus.vga_vsync <= 1'b1;
      bus.vblank    <= 1'b0;
    end else if (bus.pix_en) begin
      bus.ram_addr  <= ADDR_W'(s0_addr);
      dly_pipe      <= {dly_pipe[RD_LAT-1:0], s0};
      bus.vga_rgb   <= tap.act ? bus.ram_data[2:0] : 3'd0;
      bus.vga_hsync <= ~tap.hs;
      bus.vga_vsync <= ~tap.vs;
      bus.vblank    <= tap.vb;
    end
  end

  assign bus.ram_re      = bus.pix_en;
  assign bus.frame_start = tap.first & bus.pix_en;
  assign unused_data_hi  = ^bus.ram_data[7:3];

endmodule
